// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Arbitrates N_PORT requesters onto a single downstream memory port. One
//   transaction is in flight at a time: IDLE picks a winner and latches its
//   command, BUSY drives the latched command until mem_ack or timeout, and
//   DONE returns a one-cycle req_ack (plus req_err on timeout) to the winner.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_re/req_we     per-port read/write request levels
//   req_addr/wdata/len  per-port command, port i at [i*W +: W]
//   req_rdata         read data, valid with req_ack
//   req_ack/req_err   per-port completion pulse / timeout flag
//   mem_re/mem_we     downstream strobes (BUSY only)
//   mem_addr/wdata/len  downstream command (latched)
//   mem_rdata/mem_ack downstream read data / completion
//   grant_idx         current or last granted port
//   busy              high outside IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int N_PORT    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 2,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORT-1:0]           req_re,
    input  logic [N_PORT-1:0]           req_we,
    input  logic [N_PORT*ADDR_W-1:0]    req_addr,
    input  logic [N_PORT*DATA_W-1:0]    req_wdata,
    input  logic [N_PORT*LEN_W-1:0]     req_len,
    output logic [DATA_W-1:0]           req_rdata,
    output logic [N_PORT-1:0]           req_ack,
    output logic [N_PORT-1:0]           req_err,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [LEN_W-1:0]            mem_len,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [$clog2(N_PORT)-1:0]   grant_idx,
    output logic                        busy
);

    localparam int GW = $clog2(N_PORT);
    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    state_t            r_state, w_next;
    cmd_t              r_cmd, w_cmd;
    logic [GW-1:0]     r_grant, r_ptr, w_win;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [N_PORT-1:0] w_req;
    logic              w_found, w_grant, w_ack_ok, w_tmo;
    int                w_cand;

    assign w_req = req_re | req_we;

    // Winner search. Round-robin walks from the port after the last grant
    // with wrap; fixed priority always walks from port 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = 0;
        for (int k = 0; k < N_PORT; k++) begin
            if (PRIO_MODE == 1) begin
                w_cand = k;
            end else begin
                w_cand = int'(r_ptr) + 1 + k;
                if (w_cand >= N_PORT) w_cand = w_cand - N_PORT;
            end
            for (int i = 0; i < N_PORT; i++) begin
                if (!w_found && (w_cand == i) && w_req[i]) begin
                    w_found = 1'b1;
                    w_win   = GW'(i);
                end
            end
        end
    end

    // Command of the winning port; a write request overrides a read.
    always_comb begin
        w_cmd = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (w_win == GW'(i)) begin
                w_cmd.we    = req_we[i];
                w_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
                w_cmd.len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state. mem_ack wins over the timeout in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_ack_ok = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next  = S_BUSY;
                    w_grant = 1'b1;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    w_next   = S_DONE;
                    w_ack_ok = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latched command, grant pointer, timeout counter, response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd   <= '0;
            r_grant <= '0;
            r_ptr   <= GW'(N_PORT - 1);
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cmd   <= w_cmd;
                r_grant <= w_win;
                r_ptr   <= w_win;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (w_ack_ok) begin
                r_rdata <= mem_rdata;
                r_err   <= 1'b0;
            end else if (w_tmo) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_re    = (r_state == S_BUSY) && !r_cmd.we;
    assign mem_we    = (r_state == S_BUSY) &&  r_cmd.we;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign mem_len   = r_cmd.len;
    assign req_rdata = r_rdata;
    assign grant_idx = r_grant;

    for (genvar g = 0; g < N_PORT; g++) begin : g_port
        assign req_ack[g] = (r_state == S_DONE) && (r_grant == GW'(g));
        assign req_err[g] = (r_state == S_DONE) && (r_grant == GW'(g)) && r_err;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_PORT, default 2, number of requester channels (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter LEN_W, default 2, transfer length code width (passed through, not interpreted).
REQ-005 Parameter PRIO_MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority with port 0 highest.
REQ-006 Parameter TIMEOUT, default 255, maximum number of cycles to wait for mem_ack (1..65535).
REQ-007 Ports clk and rst: one clock; reset is synchronous and active-high.
REQ-008 req_re  in  N_PORT  per-port read request level.
REQ-009 req_we  in  N_PORT  per-port write request level.
REQ-010 req_addr  in  N_PORT*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  N_PORT*DATA_W  per-port write data, packed the same way.
REQ-012 req_len  in  N_PORT*LEN_W  per-port length code, packed the same way.
REQ-013 req_rdata  out  DATA_W  read data, valid only in the cycle where req_ack of the granted port is high.
REQ-014 req_ack  out  N_PORT  one-cycle completion pulse per port.
REQ-015 req_err  out  N_PORT  one-cycle timeout flag, coincident with req_ack.
REQ-016 mem_re, mem_we  out  1 each  downstream strobes.
REQ-017 mem_addr, mem_wdata, mem_len  out  ADDR_W, DATA_W, LEN_W  downstream command.
REQ-018 mem_rdata  in  DATA_W  downstream read data; mem_ack  in  1  downstream completion.
REQ-019 grant_idx  out  clog2(N_PORT)  currently or last granted port; busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM shall have exactly three states: IDLE, BUSY and DONE.
REQ-021 In IDLE, a port shall be requesting when req_re[i] or req_we[i] is high.
REQ-022 IDLE with at least one requesting port: at the clock edge, latch the winner's address, wdata, len and direction, load grant_idx, clear the timeout counter, and go to BUSY.
REQ-023 Latency: a request visible in cycle t shall produce mem_re or mem_we high from cycle t+1.
REQ-024 In BUSY, mem_re/mem_we and the command shall come from the latched registers and stay stable; later changes on req_* inputs shall have no effect until the next IDLE.
REQ-025 A port asserting both req_re and req_we shall be served as a write only.
REQ-026 Round-robin (PRIO_MODE=0): search starts at (last grant+1) mod N_PORT, ascending with wrap; the pointer shall update only on a grant.
REQ-027 Fixed priority (PRIO_MODE=1): the lowest-index requesting port shall always win.
REQ-028 BUSY with mem_ack high: latch mem_rdata into req_rdata and go to DONE.
REQ-029 BUSY without mem_ack: increment the timeout counter.
REQ-030 Timeout: when the counter equals TIMEOUT-1 with mem_ack low, go to DONE with the error flag set and req_rdata=0.
REQ-031 mem_ack in the same cycle as the timeout condition shall count as success, with no error.
REQ-032 DONE lasts one cycle: req_ack[grant_idx]=1, req_err[grant_idx]=timeout flag, mem_re=mem_we=0, then IDLE.
REQ-033 All other req_ack and req_err bits shall be 0 at all times.
REQ-034 mem_ack arriving in IDLE or DONE shall be ignored.
REQ-035 The minimum spacing between back-to-back grants shall be three cycles (IDLE, BUSY, DONE).
REQ-036 Requesters shall drop their request the cycle after req_ack.
REQ-037 Requests held past req_ack shall be re-served as a new transaction.

Reset
REQ-038 rst high at a clock edge: state=IDLE, round-robin pointer to N_PORT-1 (so port 0 is checked first), timeout counter=0, grant_idx=0, busy=0.
REQ-039 Reset shall force mem_re=mem_we=0, mem_addr=mem_wdata=mem_len=0, req_rdata=0, req_ack=0 and req_err=0.
REQ-040 Reset during BUSY shall abandon the transaction without asserting req_ack; a late mem_ack shall be ignored.

Verification
REQ-041 N_PORT=2, RR: port0 read addr 0x100, mem_ack after 3 cycles with mem_rdata 0xDEADBEEF -> mem_re high cycles 1-3, req_ack[0] and req_rdata=0xDEADBEEF in cycle 4, req_err=0.
REQ-042 RR: ports 0 and 1 request continuously -> grant order 0,1,0,1, each grant 3 cycles apart with immediate mem_ack.
REQ-043 PRIO_MODE=1: ports 0 and 1 request continuously -> port 0 always granted; port 1 starves.
REQ-044 TIMEOUT=4, mem_ack held low -> mem_re high exactly 4 cycles, then req_ack[g]=1, req_err[g]=1, req_rdata=0.
REQ-045 Port1 asserts re and we together with wdata 0x55 -> a single mem_we transaction with mem_wdata=0x55 and no mem_re.
REQ-046 rst asserted in BUSY cycle 2 -> all outputs 0 next cycle; mem_ack one cycle later -> no req_ack.
